// File: rtl/ram_rw_master.sv
// ram_rw_master: arbitrates IFU/LSU requests onto the single-port ram_rw bus.
// Define RAM_RW_TIMEOUT_EN to abort a bus request after TIMEOUT_CYCLES cycles without ready.
module ram_rw_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ifu_req_valid_i,
  output logic        ifu_req_ready_o,
  input  logic [63:0] ifu_addr_i,
  output logic        ifu_resp_valid_o,
  output logic [31:0] ifu_instr_o,
  output logic        ifu_err_o,
  input  logic        lsu_req_valid_i,
  output logic        lsu_req_ready_o,
  input  logic        lsu_wen_i,
  input  logic [63:0] lsu_addr_i,
  input  logic [2:0]  lsu_size_i,
  input  logic        lsu_signed_i,
  input  logic [63:0] lsu_wdata_i,
  output logic        lsu_resp_valid_o,
  output logic [63:0] lsu_rdata_o,
  output logic        lsu_err_o,
  output logic        ram_rw_cen_o,
  output logic        ram_rw_wen_o,
  output logic [63:0] ram_rw_addr_o,
  output logic [63:0] ram_rw_wdata_o,
  output logic [7:0]  ram_rw_wmask_o,
  output logic [2:0]  ram_rw_size_o,
  input  logic        ram_rw_ready_i,
  input  logic [63:0] ram_rw_data_i
);
  typedef enum logic [1:0] {IDLE, REQ, RESP, TURN} state_t;

  state_t     state;
  logic       own_lsu;
  logic       req_wen;
  logic       req_signed;
  logic [1:0] req_size;
  logic [2:0] req_off;
  logic       lsu_grant;
  logic       ifu_grant;
  logic       lsu_legal;
  logic       ifu_legal;
  logic       tmo;

  function automatic logic [7:0] lane_mask(input logic [1:0] sz, input logic [2:0] o);
    logic [7:0] base;
    case (sz)
      2'd0:    base = 8'h01;
      2'd1:    base = 8'h03;
      2'd2:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << o;
  endfunction

  function automatic logic [63:0] load_extend(input logic [63:0] d, input logic [2:0] o,
                                              input logic [1:0] sz, input logic sgn);
    logic [63:0] raw;
    raw = d >> {o, 3'b000};
    case (sz)
      2'd0:    return {{56{sgn & raw[7]}},  raw[7:0]};
      2'd1:    return {{48{sgn & raw[15]}}, raw[15:0]};
      2'd2:    return {{32{sgn & raw[31]}}, raw[31:0]};
      default: return raw;
    endcase
  endfunction

  // Grants are combinational and only offered from IDLE; LSU wins ties.
  assign lsu_grant       = rst_n && (state == IDLE) && lsu_req_valid_i;
  assign ifu_grant       = rst_n && (state == IDLE) && ifu_req_valid_i && !lsu_req_valid_i;
  assign lsu_req_ready_o = lsu_grant;
  assign ifu_req_ready_o = ifu_grant;
  assign ifu_legal       = (ifu_addr_i[1:0] == 2'b00);

  always_comb begin
    lsu_legal = 1'b0;
    case (lsu_size_i)
      3'd0:    lsu_legal = 1'b1;
      3'd1:    lsu_legal = ~lsu_addr_i[0];
      3'd2:    lsu_legal = ~|lsu_addr_i[1:0];
      3'd3:    lsu_legal = ~|lsu_addr_i[2:0];
      default: lsu_legal = 1'b0;
    endcase
  end

`ifdef RAM_RW_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              tmo_cnt <= '0;
    else if (state == REQ)   tmo_cnt <= tmo_cnt + CNT_W'(1);
    else                     tmo_cnt <= '0;
  end

  assign tmo = (state == REQ) && !ram_rw_ready_i && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      own_lsu          <= 1'b0;
      req_wen          <= 1'b0;
      req_signed       <= 1'b0;
      req_size         <= 2'd0;
      req_off          <= 3'd0;
      ifu_resp_valid_o <= 1'b0;
      ifu_instr_o      <= '0;
      ifu_err_o        <= 1'b0;
      lsu_resp_valid_o <= 1'b0;
      lsu_rdata_o      <= '0;
      lsu_err_o        <= 1'b0;
      ram_rw_cen_o     <= 1'b0;
      ram_rw_wen_o     <= 1'b0;
      ram_rw_addr_o    <= '0;
      ram_rw_wdata_o   <= '0;
      ram_rw_wmask_o   <= '0;
      ram_rw_size_o    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (lsu_grant) begin
            own_lsu    <= 1'b1;
            req_wen    <= lsu_wen_i;
            req_signed <= lsu_signed_i;
            req_size   <= lsu_size_i[1:0];
            req_off    <= lsu_addr_i[2:0];
            if (lsu_legal) begin
              state          <= REQ;
              ram_rw_cen_o   <= 1'b1;
              ram_rw_wen_o   <= lsu_wen_i;
              ram_rw_addr_o  <= {lsu_addr_i[63:3], 3'b000};
              ram_rw_wdata_o <= lsu_wen_i ? (lsu_wdata_i << {lsu_addr_i[2:0], 3'b000}) : '0;
              ram_rw_wmask_o <= lsu_wen_i ? lane_mask(lsu_size_i[1:0], lsu_addr_i[2:0]) : '0;
              ram_rw_size_o  <= lsu_size_i;
            end else begin
              state            <= RESP;
              lsu_resp_valid_o <= 1'b1;
              lsu_err_o        <= 1'b1;
              lsu_rdata_o      <= '0;
            end
          end else if (ifu_grant) begin
            own_lsu    <= 1'b0;
            req_wen    <= 1'b0;
            req_signed <= 1'b0;
            req_size   <= 2'd3;
            req_off    <= ifu_addr_i[2:0];
            if (ifu_legal) begin
              state          <= REQ;
              ram_rw_cen_o   <= 1'b1;
              ram_rw_wen_o   <= 1'b0;
              ram_rw_addr_o  <= {ifu_addr_i[63:3], 3'b000};
              ram_rw_wdata_o <= '0;
              ram_rw_wmask_o <= '0;
              ram_rw_size_o  <= 3'd3;
            end else begin
              state            <= RESP;
              ifu_resp_valid_o <= 1'b1;
              ifu_err_o        <= 1'b1;
              ifu_instr_o      <= '0;
            end
          end
        end
        REQ: begin
          if (ram_rw_ready_i || tmo) begin
            state          <= RESP;
            ram_rw_cen_o   <= 1'b0;
            ram_rw_wen_o   <= 1'b0;
            ram_rw_wmask_o <= '0;
            if (own_lsu) begin
              lsu_resp_valid_o <= 1'b1;
              lsu_err_o        <= !ram_rw_ready_i;
              lsu_rdata_o      <= (ram_rw_ready_i && !req_wen) ?
                                  load_extend(ram_rw_data_i, req_off, req_size, req_signed) : '0;
            end else begin
              ifu_resp_valid_o <= 1'b1;
              ifu_err_o        <= !ram_rw_ready_i;
              ifu_instr_o      <= !ram_rw_ready_i ? '0 :
                                  (req_off[2] ? ram_rw_data_i[63:32] : ram_rw_data_i[31:0]);
            end
          end
        end
        RESP: begin
          ifu_resp_valid_o <= 1'b0;
          lsu_resp_valid_o <= 1'b0;
          state            <= TURN;
        end
        // Responder's ready lags cen by a cycle; it is deliberately not sampled here.
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_rw_master.sv
// Directed and randomized bench for ram_rw_master against a byte-level reference model.
module tb_ram_rw_master;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu_req_valid_i, ifu_req_ready_o, ifu_resp_valid_o, ifu_err_o;
  logic [63:0] ifu_addr_i;
  logic [31:0] ifu_instr_o;
  logic        lsu_req_valid_i, lsu_req_ready_o, lsu_wen_i, lsu_signed_i;
  logic [63:0] lsu_addr_i, lsu_wdata_i, lsu_rdata_o;
  logic [2:0]  lsu_size_i;
  logic        lsu_resp_valid_o, lsu_err_o;
  logic        ram_rw_cen_o, ram_rw_wen_o, ram_rw_ready_i;
  logic [63:0] ram_rw_addr_o, ram_rw_wdata_o, ram_rw_data_i;
  logic [7:0]  ram_rw_wmask_o;
  logic [2:0]  ram_rw_size_o;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [63:0] obs_addr, obs_wdata;
  logic [7:0]  obs_wmask;
  logic        obs_wen;

  always #5 clk = ~clk;

  ram_rw_master #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid_i(ifu_req_valid_i), .ifu_req_ready_o(ifu_req_ready_o),
    .ifu_addr_i(ifu_addr_i), .ifu_resp_valid_o(ifu_resp_valid_o),
    .ifu_instr_o(ifu_instr_o), .ifu_err_o(ifu_err_o),
    .lsu_req_valid_i(lsu_req_valid_i), .lsu_req_ready_o(lsu_req_ready_o),
    .lsu_wen_i(lsu_wen_i), .lsu_addr_i(lsu_addr_i), .lsu_size_i(lsu_size_i),
    .lsu_signed_i(lsu_signed_i), .lsu_wdata_i(lsu_wdata_i),
    .lsu_resp_valid_o(lsu_resp_valid_o), .lsu_rdata_o(lsu_rdata_o), .lsu_err_o(lsu_err_o),
    .ram_rw_cen_o(ram_rw_cen_o), .ram_rw_wen_o(ram_rw_wen_o), .ram_rw_addr_o(ram_rw_addr_o),
    .ram_rw_wdata_o(ram_rw_wdata_o), .ram_rw_wmask_o(ram_rw_wmask_o),
    .ram_rw_size_o(ram_rw_size_o), .ram_rw_ready_i(ram_rw_ready_i),
    .ram_rw_data_i(ram_rw_data_i)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: byte lanes computed one byte at a time.
  function automatic logic m_legal(input int sz, input int o);
    return (sz <= 3) && ((o % (1 << sz)) == 0);
  endfunction

  function automatic logic [7:0] m_mask(input int sz, input int o);
    logic [7:0] m = '0;
    for (int i = 0; i < (1 << sz); i++) m[o + i] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] m_wdata(input logic [63:0] wd, input int o);
    logic [63:0] r = '0;
    for (int i = 0; i + o < 8; i++) r[8*(o+i) +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  function automatic logic [63:0] m_rdata(input logic [63:0] d, input int sz, input int o,
                                          input logic sgn);
    logic [63:0] v = '0;
    int n = 1 << sz;
    for (int i = 0; i < n; i++) v[8*i +: 8] = d[8*(o+i) +: 8];
    if (sgn && v[8*n-1])
      for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_ifu_ready"}, ifu_req_ready_o, 0);
    check({tag, "_ifu_rvalid"}, ifu_resp_valid_o, 0);
    check({tag, "_ifu_instr"}, ifu_instr_o, 0);
    check({tag, "_ifu_err"}, ifu_err_o, 0);
    check({tag, "_lsu_ready"}, lsu_req_ready_o, 0);
    check({tag, "_lsu_rvalid"}, lsu_resp_valid_o, 0);
    check({tag, "_lsu_rdata"}, lsu_rdata_o, 0);
    check({tag, "_lsu_err"}, lsu_err_o, 0);
    check({tag, "_cen"}, ram_rw_cen_o, 0);
    check({tag, "_wen"}, ram_rw_wen_o, 0);
    check({tag, "_addr"}, ram_rw_addr_o, 0);
    check({tag, "_wdata"}, ram_rw_wdata_o, 0);
    check({tag, "_wmask"}, ram_rw_wmask_o, 0);
    check({tag, "_size"}, ram_rw_size_o, 0);
  endtask

  // Starts and ends at a negedge inside an IDLE cycle.
  task automatic run_lsu(input logic wen, input logic [63:0] addr, input logic [2:0] sz,
                         input logic sgn, input logic [63:0] wd, input logic [63:0] bus,
                         input int lat);
    int   o = int'(addr[2:0]);
    logic legal = m_legal(int'(sz), o);
    lsu_req_valid_i = 1'b1; lsu_wen_i = wen; lsu_addr_i = addr;
    lsu_size_i = sz; lsu_signed_i = sgn; lsu_wdata_i = wd;
    #1;
    check("lsu_grant", lsu_req_ready_o, 1);
    check("ifu_blocked", ifu_req_ready_o, 0);
    step();
    lsu_req_valid_i = 1'b0;
    if (legal) begin
      for (int c = 1; c <= lat; c++) begin
        check("lsu_cen_req", ram_rw_cen_o, 1);
        check("lsu_no_early_resp", lsu_resp_valid_o, 0);
        check("lsu_ready_busy", lsu_req_ready_o, 0);
        if (c == 1) begin
          obs_addr = ram_rw_addr_o; obs_wdata = ram_rw_wdata_o;
          obs_wmask = ram_rw_wmask_o; obs_wen = ram_rw_wen_o;
          check("lsu_addr", ram_rw_addr_o, addr & ~64'h7);
          check("lsu_wen", ram_rw_wen_o, wen);
          check("lsu_size", ram_rw_size_o, sz);
          check("lsu_wmask", ram_rw_wmask_o, wen ? m_mask(int'(sz), o) : 8'h00);
          if (wen) check("lsu_wdata", ram_rw_wdata_o, m_wdata(wd, o));
        end
        if (c == lat) begin ram_rw_ready_i = 1'b1; ram_rw_data_i = bus; end
        step();
        ram_rw_ready_i = 1'b0;
        ram_rw_data_i = {$urandom, $urandom};
      end
    end else begin
      check("lsu_illegal_no_cen", ram_rw_cen_o, 0);
    end
    check("lsu_rvalid", lsu_resp_valid_o, 1);
    check("lsu_err", lsu_err_o, !legal);
    if (legal) check("lsu_rdata", lsu_rdata_o, wen ? 64'h0 : m_rdata(bus, int'(sz), o, sgn));
    check("lsu_resp_cen", ram_rw_cen_o, 0);
    check("lsu_resp_ifu_quiet", ifu_resp_valid_o, 0);
    step();
    check("lsu_turn_rvalid", lsu_resp_valid_o, 0);
    check("lsu_turn_cen", ram_rw_cen_o, 0);
    check("lsu_turn_ready", lsu_req_ready_o, 0);
    ram_rw_ready_i = 1'b1;
    step();
    ram_rw_ready_i = 1'b0;
    check("lsu_idle_rvalid", lsu_resp_valid_o, 0);
    check("lsu_idle_ifu_rvalid", ifu_resp_valid_o, 0);
    check("lsu_idle_cen", ram_rw_cen_o, 0);
  endtask

  task automatic run_ifu(input logic [63:0] addr, input logic [63:0] bus, input int lat);
    logic legal = (addr[1:0] == 2'b00);
    int   o = int'(addr[2:0]);
    ifu_req_valid_i = 1'b1; ifu_addr_i = addr;
    #1;
    check("ifu_grant", ifu_req_ready_o, 1);
    step();
    ifu_req_valid_i = 1'b0;
    if (legal) begin
      for (int c = 1; c <= lat; c++) begin
        check("ifu_cen_req", ram_rw_cen_o, 1);
        check("ifu_no_early_resp", ifu_resp_valid_o, 0);
        if (c == 1) begin
          check("ifu_addr", ram_rw_addr_o, addr & ~64'h7);
          check("ifu_wen", ram_rw_wen_o, 0);
          check("ifu_wmask", ram_rw_wmask_o, 0);
          check("ifu_size", ram_rw_size_o, 3);
        end
        if (c == lat) begin ram_rw_ready_i = 1'b1; ram_rw_data_i = bus; end
        step();
        ram_rw_ready_i = 1'b0;
      end
    end else begin
      check("ifu_illegal_no_cen", ram_rw_cen_o, 0);
    end
    check("ifu_rvalid", ifu_resp_valid_o, 1);
    check("ifu_err", ifu_err_o, !legal);
    if (legal) check("ifu_instr", ifu_instr_o, bus[8*(o & 4) +: 32]);
    check("ifu_resp_lsu_quiet", lsu_resp_valid_o, 0);
    step();
    check("ifu_turn_rvalid", ifu_resp_valid_o, 0);
    ram_rw_ready_i = 1'b1;
    step();
    ram_rw_ready_i = 1'b0;
    check("ifu_idle_rvalid", ifu_resp_valid_o, 0);
    check("ifu_idle_cen", ram_rw_cen_o, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    ifu_req_valid_i = 1'b1; ifu_addr_i = 64'h8000_0000;
    lsu_req_valid_i = 1'b1; lsu_wen_i = 1'b0; lsu_addr_i = 64'h8000_0000;
    lsu_size_i = 3'd3; lsu_signed_i = 1'b0; lsu_wdata_i = '0;
    ram_rw_ready_i = 1'b0; ram_rw_data_i = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    ifu_req_valid_i = 1'b0; lsu_req_valid_i = 1'b0;
    rst_n = 1'b1;
    step();

    run_ifu(64'h8000_0004, 64'h0010_0093_0000_0513, 2);
    check("tp_fetch_instr", ifu_instr_o, 64'h0010_0093);

    run_lsu(1'b0, 64'h8000_0013, 3'd0, 1'b1, 64'h0, 64'h0000_0000_8000_0000, 2);
    check("tp_lb_signed", lsu_rdata_o, 64'hFFFF_FFFF_FFFF_FF80);
    run_lsu(1'b0, 64'h8000_0013, 3'd0, 1'b0, 64'h0, 64'h0000_0000_8000_0000, 2);
    check("tp_lb_unsigned", lsu_rdata_o, 64'h80);

    run_lsu(1'b1, 64'h8000_0006, 3'd1, 1'b0, 64'hBEEF, 64'h1234, 2);
    check("tp_sh_wmask", obs_wmask, 8'hC0);
    check("tp_sh_wdata", obs_wdata, 64'hBEEF_0000_0000_0000);
    check("tp_sh_addr", obs_addr, 64'h8000_0000);
    check("tp_sh_wen", obs_wen, 1);
    check("tp_sh_rdata", lsu_rdata_o, 0);

    // Both requesters at once: LSU first, IFU keeps its request up through TURN.
    ifu_req_valid_i = 1'b1; ifu_addr_i = 64'h8000_0100;
    run_lsu(1'b0, 64'h8000_0200, 3'd2, 1'b0, 64'h0, 64'hCAFE_F00D_1234_5678, 2);
    check("tp_arb_lsu_data", lsu_rdata_o, 64'h1234_5678);
    run_ifu(64'h8000_0100, 64'hAAAA_BBBB_CCCC_DDDD, 1);

    run_lsu(1'b0, 64'h8000_0002, 3'd2, 1'b0, 64'h0, 64'h0, 1);
    run_ifu(64'h8000_0002, 64'h0, 1);
    check("tp_ifu_misalign_err", ifu_err_o, 1);
    run_lsu(1'b0, 64'h8000_0000, 3'd5, 1'b0, 64'h0, 64'h0, 1);

`ifdef RAM_RW_TIMEOUT_EN
    lsu_req_valid_i = 1'b1; lsu_wen_i = 1'b0; lsu_addr_i = 64'h8000_0008;
    lsu_size_i = 3'd3; lsu_signed_i = 1'b0;
    step();
    lsu_req_valid_i = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      check("tmo_cen_high", ram_rw_cen_o, 1);
      check("tmo_no_resp", lsu_resp_valid_o, 0);
      step();
    end
    check("tmo_cen_drop", ram_rw_cen_o, 0);
    check("tmo_rvalid", lsu_resp_valid_o, 1);
    check("tmo_err", lsu_err_o, 1);
    check("tmo_rdata", lsu_rdata_o, 0);
    step();
    step();
`else
    run_lsu(1'b0, 64'h8000_0008, 3'd3, 1'b0, 64'h0, 64'h0123_4567_89AB_CDEF, 12);
`endif

    // Reset dropped while a request is on the bus.
    lsu_req_valid_i = 1'b1; lsu_wen_i = 1'b1; lsu_addr_i = 64'h8000_0010;
    lsu_size_i = 3'd3; lsu_wdata_i = 64'h5555_6666_7777_8888;
    step();
    lsu_req_valid_i = 1'b0;
    check("rst_mid_cen_before", ram_rw_cen_o, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    ram_rw_ready_i = 1'b1;
    step();
    ram_rw_ready_i = 1'b0;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      check("rst_after_no_resp", lsu_resp_valid_o, 0);
      check("rst_after_cen", ram_rw_cen_o, 0);
      step();
    end

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        logic [63:0] a = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_FFF8)};
        a[2] = $urandom_range(0, 1) == 1;
        if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
        run_ifu(a, {$urandom, $urandom}, $urandom_range(1, 3));
      end else begin
        int          sz = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3);
        int          o  = $urandom_range(0, 7);
        logic [63:0] a;
        if (sz <= 3 && $urandom_range(0, 3) != 0) o = o & ~((1 << sz) - 1);
        a = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_FFF8)} | 64'(o);
        run_lsu(1'($urandom_range(0, 1)), a, 3'(sz), 1'($urandom_range(0, 1)),
                {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(1, 3));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/ram_rw_master.md
# ram_rw_master

Core-side initiator for the single-port `ram_rw` memory bus: arbitrates instruction-fetch (IFU) and load/store (LSU) requests and runs each one as a `ram_rw` transaction. It drives the 8-byte-aligned address and builds byte-lane write masks and data. It extracts the requested bytes from the returned doubleword. Sits inside `rvcpu` between IFU/LSU and the `ram_rw_*` ports; the top-level RAM wrapper is the responder.

## Interface
- `TIMEOUT_CYCLES`, 255 — max cycles waiting for `ram_rw_ready_i` (used only with the timeout feature).
- `clk` in 1 — core clock.
- `rst_n` in 1 — reset, asynchronous, active-low.
- `ifu_req_valid_i` in 1 — fetch request.
- `ifu_req_ready_o` out 1 — fetch accepted this cycle.
- `ifu_addr_i` in 64 — fetch byte address.
- `ifu_resp_valid_o` out 1 — one-cycle fetch completion pulse.
- `ifu_instr_o` out 32 — fetched instruction.
- `ifu_err_o` out 1 — fetch error, qualified by `ifu_resp_valid_o`.
- `lsu_req_valid_i` in 1 — load/store request.
- `lsu_req_ready_o` out 1 — LSU request accepted.
- `lsu_wen_i` in 1 — 1 = store.
- `lsu_addr_i` in 64 — byte address.
- `lsu_size_i` in 3 — 0 byte, 1 half, 2 word, 3 double.
- `lsu_signed_i` in 1 — sign-extend load result.
- `lsu_wdata_i` in 64 — store data, LSB-aligned.
- `lsu_resp_valid_o` out 1 — one-cycle completion pulse.
- `lsu_rdata_o` out 64 — extended load data.
- `lsu_err_o` out 1 — error, qualified by `lsu_resp_valid_o`.
- `ram_rw_cen_o` out 1 — bus request.
- `ram_rw_wen_o` out 1 — bus write.
- `ram_rw_addr_o` out 64 — `{addr[63:3],3'b0}`.
- `ram_rw_wdata_o` out 64 — lane-shifted store data.
- `ram_rw_wmask_o` out 8 — byte-lane mask.
- `ram_rw_size_o` out 3 — copy of the request size (3 for fetch).
- `ram_rw_ready_i` in 1 — responder completion.
- `ram_rw_data_i` in 64 — read doubleword.

## Operation
- FSM states: IDLE, REQ, RESP, TURN.
- IDLE: the LSU has fixed priority over the IFU; the ready outputs are combinational grants, only in IDLE.
- Accepted request with a legal access → REQ. All `ram_rw_*` outputs are registered and held stable for the whole of REQ.
- Illegal access → RESP with err=1 and no bus activity. Illegal means:
  - LSU `size>3`;
  - LSU `addr[2:0]` not a multiple of `1<<size`;
  - IFU `addr[1:0]!=0`.
- REQ: `ram_rw_cen_o=1`. When `ram_rw_ready_i=1`, capture `ram_rw_data_i` and go to RESP.
- RESP: pulse the owner's `*_resp_valid_o` for one cycle, then go to TURN.
- TURN: one cycle with `cen=0`. `ram_rw_ready_i` is ignored here (the responder's ready lags `cen` by one cycle), then go to IDLE.
- Store lanes, with `o=addr[2:0]`:
  - `wmask = ((1<<(1<<size))-1) << o`;
  - `wdata = lsu_wdata_i << (8*o)`;
  - `ram_rw_wen_o` is 0 for loads and fetches.
- Load data: `raw = data >> (8*o)`, truncated to the access size, then zero- or sign-extended per `lsu_signed_i`. A store returns `lsu_rdata_o=0`.
- Fetch data: `ifu_instr_o = addr[2] ? data[63:32] : data[31:0]`; `wmask` is 0 for fetches.
- Response data outputs hold until the next response.

## Timing
- Reset: state=IDLE; every output is 0, including the ready outputs.
- Reset asserted mid-transaction: the transaction is abandoned, `cen` drops immediately, and no response is issued.
- Legal access, with request accepted in cycle 0:
  - `cen` high in cycles 1..k, where k is the first cycle with ready (k≥1, typically 2);
  - resp_valid in cycle k+1;
  - TURN in cycle k+2;
  - next accept possible in cycle k+3.
- Illegal access: resp_valid in cycle 1, TURN in cycle 2.
- Simultaneous IFU+LSU valid in IDLE: the LSU is granted and the IFU waits, with its inputs held.
- Requesters must hold `*_req_*` inputs stable until ready.

## Configuration
- `RAM_RW_TIMEOUT_EN` defined: a counter runs in REQ. After `TIMEOUT_CYCLES` cycles without `ram_rw_ready_i`, the block drops `cen` and goes to RESP with err=1; the read data outputs are 0.
- Not defined: no counter; REQ waits indefinitely.

## Test plan
- IFU fetch `0x80000004`, data `0x00100093_00000513`, ready in cycle 2 → `cen` cycles 1–2, `ifu_instr_o=0x00100093`, resp in cycle 3, err=0.
- LSU signed byte load `0x80000013`, data `0x0000_0000_8000_0000` → `lsu_rdata_o=0xFFFF_FFFF_FFFF_FF80`; unsigned → `0x80`.
- LSU half store `0x80000006`, wdata `0xBEEF` → `wmask=0xC0`, `wdata=0xBEEF_0000_0000_0000`, `addr=0x80000000`, `wen=1`.
- IFU and LSU valid in the same cycle → LSU is granted first. The IFU is granted only after TURN, and the stale ready in TURN causes no spurious completion.
- Misaligned word load `0x80000002` → err=1 at cycle 1, `cen` never asserted. IFU `0x80000002` → `ifu_err_o=1`.
- With `RAM_RW_TIMEOUT_EN` and `TIMEOUT_CYCLES=4`, ready held low → `cen` drops after 4 cycles and `lsu_err_o=1`. Also assert `rst_n` low mid-REQ → all outputs 0 and no resp_valid.
